// File: rtl/tx_subcarrier_map.sv
// tx_subcarrier_map
//   Takes the mapper's 52 used-subcarrier samples per OFDM symbol (arrival
//   order -26..-1, +1..+26) and streams 64 samples per symbol to the IFFT in
//   bin order, with DC (bin 0) and guard bins 27..37 forced to zero. Two
//   52-word banks form a ping-pong buffer, so one symbol can be written while
//   the previous one is being read out.
//
// Ports
//   clk_Modulation              sole clock
//   reset                       asynchronous active-high reset
//   tx_modulate_out_valid/re/im mapper sample stream, one sample per valid cycle
//   tx_freq_to_timed_cycle_flag high when the next 52-sample symbol can start
//   ifft_in_valid/ready         output handshake (AXI-stream style)
//   ifft_in_re/im/last          output sample; last marks the 64th sample
//   sym_cnt                     symbols fully delivered since reset (wraps)
//   err_overflow                sticky: a sample arrived while its bank was full
//
// Build option
//   TX_SUBMAP_BITREV_EN  defined: output position j carries bin bitrev6(j)
//                        undefined: natural order, bin = j
//
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for the read bank to be committed full
//   R_RUN  | issuing output positions 0..63 of the read bank
module tx_subcarrier_map #(
  parameter int DATA_W = 32
) (
  input  logic              clk_Modulation,
  input  logic              reset,
  input  logic              tx_modulate_out_valid,
  input  logic [DATA_W-1:0] tx_modulate_re_out,
  input  logic [DATA_W-1:0] tx_modulate_im_out,
  output logic              tx_freq_to_timed_cycle_flag,
  output logic              ifft_in_valid,
  input  logic              ifft_in_ready,
  output logic [DATA_W-1:0] ifft_in_re,
  output logic [DATA_W-1:0] ifft_in_im,
  output logic              ifft_in_last,
  output logic [15:0]       sym_cnt,
  output logic              err_overflow
);

  typedef enum logic {R_IDLE, R_RUN} rd_state_e;

  // Bank b occupies words b*52 .. b*52+51; word index = arrival index k.
  logic [2*DATA_W-1:0] bank_mem [0:103];

  logic [5:0]        wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic [1:0]        full_q, full_d;
  logic              rd_bank_q, rd_bank_d;
  rd_state_e         state_q, state_d;
  logic [6:0]        rd_j_q, rd_j_d;          // 64 = all positions issued
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_re_q, out_re_d;
  logic [DATA_W-1:0] out_im_q, out_im_d;
  logic [15:0]       sym_cnt_q, sym_cnt_d;
  logic              err_q, err_d;

  logic              wr_full, wr_en;
  logic [6:0]        wr_addr;
  logic              rd_bank_n, adv, last_hs, wrap, iss_en, iss_bank, iss_null;
  logic [5:0]        iss_j, iss_bin, iss_k;
  logic [6:0]        rd_addr;
  logic [2*DATA_W-1:0] rd_word;

  assign wr_full = full_q[wr_bank_q];
  assign wr_en   = tx_modulate_out_valid && !wr_full;
  assign wr_addr = wr_bank_q ? (7'd52 + {1'b0, wr_cnt_q}) : {1'b0, wr_cnt_q};

  assign rd_bank_n = ~rd_bank_q;
  assign adv       = !out_valid_q || ifft_in_ready;
  assign last_hs   = out_valid_q && out_last_q && ifft_in_ready;
  // Back-to-back: position 0 of the other bank is issued on the same edge
  // that retires position 63, so the output stream has no gap.
  assign wrap      = last_hs && full_q[rd_bank_n];
  assign iss_bank  = (rd_j_q == 7'd64) ? rd_bank_n : rd_bank_q;
  assign iss_j     = (rd_j_q == 7'd64) ? 6'd0 : rd_j_q[5:0];
  assign iss_en    = (state_q == R_RUN) && adv && ((rd_j_q != 7'd64) || wrap);

`ifdef TX_SUBMAP_BITREV_EN
  assign iss_bin = {iss_j[0], iss_j[1], iss_j[2], iss_j[3], iss_j[4], iss_j[5]};
`else
  assign iss_bin = iss_j;
`endif

  assign iss_null = (iss_bin == 6'd0) || ((iss_bin >= 6'd27) && (iss_bin <= 6'd37));
  // Negative subcarriers (bins 38..63) arrived first as k = 0..25.
  assign iss_k    = (iss_bin >= 6'd38) ? (iss_bin - 6'd38) : (iss_bin + 6'd25);
  assign rd_addr  = iss_bank ? (7'd52 + {1'b0, iss_k}) : {1'b0, iss_k};
  assign rd_word  = bank_mem[rd_addr];

  always_ff @(posedge clk_Modulation) begin
    if (wr_en) bank_mem[wr_addr] <= {tx_modulate_re_out, tx_modulate_im_out};
  end

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    full_d      = full_q;
    rd_bank_d   = rd_bank_q;
    state_d     = state_q;
    rd_j_d      = rd_j_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    sym_cnt_d   = sym_cnt_q;
    err_d       = err_q;

    if (tx_modulate_out_valid) begin
      if (wr_full) begin
        err_d = 1'b1;
      end else if (wr_cnt_q == 6'd51) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = 6'd0;
      end else begin
        wr_cnt_d = wr_cnt_q + 6'd1;
      end
    end

    if (out_valid_q && ifft_in_ready) out_valid_d = 1'b0;

    case (state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = R_RUN;
          rd_j_d  = 7'd0;
        end
      end
      R_RUN: begin
        if (last_hs) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = rd_bank_n;
          sym_cnt_d         = sym_cnt_q + 16'd1;
          if (!full_q[rd_bank_n]) begin
            state_d = R_IDLE;
            rd_j_d  = 7'd0;
          end
        end
        if (iss_en) begin
          out_valid_d = 1'b1;
          out_last_d  = (iss_j == 6'd63);
          out_re_d    = iss_null ? '0 : rd_word[2*DATA_W-1:DATA_W];
          out_im_d    = iss_null ? '0 : rd_word[DATA_W-1:0];
          rd_j_d      = {1'b0, iss_j} + 7'd1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_Modulation or posedge reset) begin
    if (reset) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      full_q      <= '0;
      rd_bank_q   <= 1'b0;
      state_q     <= R_IDLE;
      rd_j_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      sym_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      rd_bank_q   <= rd_bank_d;
      state_q     <= state_d;
      rd_j_q      <= rd_j_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      sym_cnt_q   <= sym_cnt_d;
      err_q       <= err_d;
    end
  end

  // Flag is forced low during reset so every output reads 0 while held.
  assign tx_freq_to_timed_cycle_flag = !reset && (wr_cnt_q == 6'd0) &&
                                       !tx_modulate_out_valid && !wr_full;
  assign ifft_in_valid = out_valid_q;
  assign ifft_in_re    = out_re_q;
  assign ifft_in_im    = out_im_q;
  assign ifft_in_last  = out_last_q;
  assign sym_cnt       = sym_cnt_q;
  assign err_overflow  = err_q;

endmodule

// File: tb/tb_tx_subcarrier_map.sv
`timescale 1ns/1ps
module tb_tx_subcarrier_map;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              vin;
  logic [DATA_W-1:0] re_in, im_in;
  logic              flag;
  logic              ifft_in_valid, ifft_in_ready, ifft_in_last;
  logic [DATA_W-1:0] ifft_in_re, ifft_in_im;
  logic [15:0]       sym_cnt;
  logic              err_overflow;

  always #5 clk = ~clk;

  tx_subcarrier_map #(.DATA_W(DATA_W)) dut (
    .clk_Modulation              (clk),
    .reset                       (rst),
    .tx_modulate_out_valid       (vin),
    .tx_modulate_re_out          (re_in),
    .tx_modulate_im_out          (im_in),
    .tx_freq_to_timed_cycle_flag (flag),
    .ifft_in_valid               (ifft_in_valid),
    .ifft_in_ready               (ifft_in_ready),
    .ifft_in_re                  (ifft_in_re),
    .ifft_in_im                  (ifft_in_im),
    .ifft_in_last                (ifft_in_last),
    .sym_cnt                     (sym_cnt),
    .err_overflow                (err_overflow)
  );

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } smp_t;

  smp_t exp_q[$];
  smp_t cap [0:63];
  int   cap_base = 0;
  int   n_cmp = 0, n_fail = 0;
  int   hs_total = 0, cyc = 0;
  int   hs_cyc [0:1023];
  int   ready_mode = 0;   // 0: ready=1, 1: random, 2: ready=0
  logic stall_prev = 1'b0;
  smp_t prev_s;

  initial begin
    ifft_in_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       ifft_in_ready = 1'b1;
        1:       ifft_in_ready = 1'($urandom_range(0, 1));
        default: ifft_in_ready = 1'b0;
      endcase
    end
  end

  // Output monitor / scoreboard
  always @(negedge clk) begin
    smp_t obs, e;
    cyc++;
    obs = {ifft_in_last, ifft_in_re, ifft_in_im};
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_cmp++;
        assert (ifft_in_valid === 1'b1 && obs === prev_s) else begin
          n_fail++;
          $error("FAIL hold_stable observed=%h expected=%h", {ifft_in_valid, obs}, {1'b1, prev_s});
        end
      end
      if (ifft_in_valid === 1'b1 && ifft_in_ready === 1'b1) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_output observed=%h expected=none", obs);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_cmp++;
          assert (obs === e) else begin
            n_fail++;
            $error("FAIL out_sample#%0d observed=%h expected=%h", hs_total, obs, e);
          end
        end
        if (hs_total >= cap_base && hs_total < cap_base + 64) cap[hs_total - cap_base] = obs;
        hs_cyc[hs_total % 1024] = cyc;
        hs_total++;
      end
      stall_prev = ifft_in_valid && !ifft_in_ready;
      prev_s     = obs;
    end
  end

  function automatic int br6(input int j);
    int r = 0;
    for (int i = 0; i < 6; i++) if (j[i]) r = r | (1 << (5 - i));
    return r;
  endfunction

  // Reference model: forward-map arrival index to bin, then emit 64 positions.
  task automatic push_sym(input int base);
    logic [DATA_W-1:0] bre [64];
    logic [DATA_W-1:0] bim [64];
    int bin, b;
    for (int i = 0; i < 64; i++) begin bre[i] = '0; bim[i] = '0; end
    for (int k = 0; k < 52; k++) begin
      bin = (k < 26) ? 38 + k : k - 25;
      bre[bin] = 32'(base + k + 1);
      bim[bin] = 32'(-(base + k + 1));
    end
    for (int j = 0; j < 64; j++) begin
`ifdef TX_SUBMAP_BITREV_EN
      b = br6(j);
`else
      b = j;
`endif
      exp_q.push_back({(j == 63), bre[b], bim[b]});
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_sym(input int base, input bit push);
    if (push) push_sym(base);
    @(posedge clk); #1;
    for (int k = 0; k < 52; k++) begin
      vin   = 1'b1;
      re_in = 32'(base + k + 1);
      im_in = 32'(-(base + k + 1));
      step(1);
    end
    vin = 1'b0;
  endtask

  task automatic wait_flag(input string tag);
    int n = 0;
    #1;
    while (flag !== 1'b1 && n < 400) begin @(posedge clk); #2; n++; end
    check(tag, 32'(flag), 32'd1);
  endtask

  task automatic wait_hs(input int target, input int budget, input string tag);
    int n = 0;
    while (hs_total < target && n < budget) begin step(1); n++; end
    n_cmp++;
    assert (hs_total >= target) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, hs_total, target);
    end
  endtask

  task automatic check_zero_out(input string tag);
    check({tag, "_valid"}, 32'(ifft_in_valid), 32'd0);
    check({tag, "_re"},    ifft_in_re,         32'd0);
    check({tag, "_im"},    ifft_in_im,         32'd0);
    check({tag, "_last"},  32'(ifft_in_last),  32'd0);
    check({tag, "_symcnt"}, 32'(sym_cnt),      32'd0);
    check({tag, "_err"},   32'(err_overflow),  32'd0);
    check({tag, "_flag"},  32'(flag),          32'd0);
  endtask

  initial begin
    int mark, mark2;
    rst = 1'b1; vin = 1'b0; re_in = '0; im_in = '0;
    step(3);
    check_zero_out("reset");
    rst = 1'b0;
    step(2);
    #1 check("flag_idle", 32'(flag), 32'd1);

    // Single symbol, ready=1
    cap_base = hs_total;
    drive_sym(0, 1'b1);
    step(1);
    check("lat_pre", 32'(ifft_in_valid), 32'd0);
    step(1);
    check("lat_first", 32'(ifft_in_valid), 32'd1);
    wait_hs(cap_base + 64, 300, "s1_drain");
    step(2);
`ifdef TX_SUBMAP_BITREV_EN
    check("br_j0", cap[0].re | cap[0].im, 32'd0);
    check("br_j1_bin32", cap[1].re | cap[1].im, 32'd0);
    check("br_j2_bin16_re", cap[2].re, 32'd42);
    check("br_j63_re", cap[63].re, 32'd26);
    check("br_j63_last", 32'(cap[63].last), 32'd1);
`else
    check("bin0", cap[0].re | cap[0].im, 32'd0);
    check("bin1_re", cap[1].re, 32'd27);
    check("bin26_re", cap[26].re, 32'd52);
    for (int b = 27; b <= 37; b++) check($sformatf("guard%0d", b), cap[b].re | cap[b].im, 32'd0);
    check("bin38_re", cap[38].re, 32'd1);
    check("bin38_im", cap[38].im, 32'hFFFF_FFFF);
    check("bin63_re", cap[63].re, 32'd26);
    check("bin62_last", 32'(cap[62].last), 32'd0);
    check("bin63_last", 32'(cap[63].last), 32'd1);
`endif
    check("s1_symcnt", 32'(sym_cnt), 32'd1);
    check("s1_q_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back three symbols, mapper waits on the flag
    mark = hs_total;
    wait_flag("b2b_flag1");
    drive_sym(1000, 1'b1);
    wait_flag("b2b_flag2");
    drive_sym(2000, 1'b1);
    #1 check("flag_both_full", 32'(flag), 32'd0);
    wait_flag("b2b_flag3");
    drive_sym(3000, 1'b1);
    wait_hs(mark + 192, 600, "b2b_drain");
    check("b2b_contiguous", 32'(hs_cyc[(mark + 191) % 1024] - hs_cyc[mark % 1024]), 32'd191);
    step(2);
    check("b2b_symcnt", 32'(sym_cnt), 32'd4);
    check("b2b_err", 32'(err_overflow), 32'd0);

    // Random backpressure
    ready_mode = 1;
    mark = hs_total;
    wait_flag("bp_flag1");
    drive_sym(4000, 1'b1);
    wait_flag("bp_flag2");
    drive_sym(5000, 1'b1);
    wait_hs(mark + 128, 3000, "bp_drain");
    ready_mode = 0;
    step(3);
    check("bp_symcnt", 32'(sym_cnt), 32'd6);
    check("bp_err", 32'(err_overflow), 32'd0);
    check("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // Overflow: ready held low, three symbols ignoring the flag
    ready_mode = 2;
    step(3);
    mark = hs_total;
    drive_sym(6000, 1'b1);
    drive_sym(7000, 1'b1);
    drive_sym(8000, 1'b0);
    #1 check("ovf_err", 32'(err_overflow), 32'd1);
    check("ovf_flag_low", 32'(flag), 32'd0);
    check("ovf_no_out", 32'(hs_total - mark), 32'd0);
    ready_mode = 0;
    wait_hs(mark + 128, 600, "ovf_drain");
    step(20);
    check("ovf_exact_128", 32'(hs_total - mark), 32'd128);
    check("ovf_q_empty", 32'(exp_q.size()), 32'd0);
    check("ovf_symcnt", 32'(sym_cnt), 32'd8);
    check("ovf_sticky", 32'(err_overflow), 32'd1);
    check("ovf_flag_free", 32'(flag), 32'd1);

    // Reset during input at sample 30
    @(posedge clk); #1;
    for (int k = 0; k < 30; k++) begin
      vin = 1'b1; re_in = 32'(9500 + k); im_in = 32'(k);
      step(1);
    end
    rst = 1'b1; vin = 1'b0;
    #1 check_zero_out("rst_in");
    step(2);
    rst = 1'b0;
    #1 check("rst_in_flag", 32'(flag), 32'd1);
    mark2 = hs_total;
    step(20);
    check("rst_in_no_out", 32'(hs_total - mark2), 32'd0);

    // Reset in the middle of output, at bin 40
    mark = hs_total;
    drive_sym(9000, 1'b1);
    wait_hs(mark + 40, 300, "rst_out_wait");
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_out_valid", 32'(ifft_in_valid), 32'd0);
    check("rst_out_re", ifft_in_re, 32'd0);
    check("rst_out_im", ifft_in_im, 32'd0);
    check("rst_out_last", 32'(ifft_in_last), 32'd0);
    step(2);
    rst = 1'b0;
    #1 check("rst_out_flag", 32'(flag), 32'd1);
    mark2 = hs_total;
    step(30);
    check("rst_out_no_stale", 32'(hs_total - mark2), 32'd0);

    // Fresh symbol after reset
    cap_base = hs_total;
    wait_flag("fresh_flag");
    drive_sym(0, 1'b1);
    wait_hs(cap_base + 64, 300, "fresh_drain");
    step(2);
    check("fresh_symcnt", 32'(sym_cnt), 32'd1);
    check("fresh_q_empty", 32'(exp_q.size()), 32'd0);
    check("fresh_j63_re", cap[63].re, 32'd26);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
